// File: rtl/feistel_pkg.sv
// -----------------------------------------------------------------------------
// feistel_pkg
// Shared types and constants for the Feistel decryption engine:
//   word_t / block_t : 16-bit word and 4-word block (w0 is the most significant)
//   state_t          : engine FSM encoding (IDLE, RUN, DONE)
//   P_SBOX / Q_SBOX  : 4-bit substitution ROMs used by the mixing function F
//   inv_round        : one inverse Feistel round, given F(s1) and F(s2)
// -----------------------------------------------------------------------------
package feistel_pkg;

   localparam int WORD_W = 16;

   typedef logic [WORD_W-1:0] word_t;

   typedef struct packed {
      word_t w0;
      word_t w1;
      word_t w2;
      word_t w3;
   } block_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [3:0] P_SBOX [16] = '{
      4'd3,  4'd15, 4'd14, 4'd0,  4'd5,  4'd4,  4'd11, 4'd12,
      4'd13, 4'd10, 4'd9,  4'd6,  4'd7,  4'd8,  4'd2,  4'd1
   };

   localparam logic [3:0] Q_SBOX [16] = '{
      4'd9,  4'd14, 4'd5,  4'd6,  4'd10, 4'd2,  4'd3,  4'd12,
      4'd15, 4'd0,  4'd4,  4'd13, 4'd7,  4'd11, 4'd1,  4'd8
   };

   // F is evaluated outside this function (two hardware instances of the
   // mixing network), so the round itself is pure XOR/NOT wiring.
   function automatic block_t inv_round(block_t s, word_t k, word_t f_s1, word_t f_s2);
      block_t n;
      n.w0 = ~s.w1 ^ k;
      n.w1 = s.w3 ^ f_s2;
      n.w2 = s.w0 ^ f_s1;
      n.w3 = ~s.w2 ^ k;
      return n;
   endfunction

endpackage

// File: rtl/feistel_decrypt_engine_if.sv
// -----------------------------------------------------------------------------
// feistel_decrypt_engine_if
// Handshake bundle between the RISC-V-facing side and the decryption engine.
//   in_valid / in_ready   : ciphertext block + key handshake
//   i_d0..i_d3, key       : ciphertext words and round key
//   out_valid / out_ready : plaintext handshake
//   o_d0..o_d3            : plaintext words
//   busy                  : engine is in RUN or DONE
// Modports: master (block producer / plaintext consumer), slave (engine).
// -----------------------------------------------------------------------------
interface feistel_decrypt_engine_if;
   import feistel_pkg::*;

   logic  in_valid;
   logic  in_ready;
   word_t i_d0;
   word_t i_d1;
   word_t i_d2;
   word_t i_d3;
   word_t key;
   logic  out_valid;
   logic  out_ready;
   word_t o_d0;
   word_t o_d1;
   word_t o_d2;
   word_t o_d3;
   logic  busy;

   modport master (
      output in_valid, i_d0, i_d1, i_d2, i_d3, key, out_ready,
      input  in_ready, out_valid, o_d0, o_d1, o_d2, o_d3, busy
   );

   modport slave (
      input  in_valid, i_d0, i_d1, i_d2, i_d3, key, out_ready,
      output in_ready, out_valid, o_d0, o_d1, o_d2, o_d3, busy
   );

endinterface

// File: rtl/feistel_mix_f.sv
// -----------------------------------------------------------------------------
// feistel_mix_f
// Purely combinational 16-bit mixing function F built from three layers of
// 4-bit S-box lookups. The input is split into nibbles {a,b,c,d}, MSB first.
// Ports:
//   x : 16-bit input word
//   y : 16-bit mixed output word
// -----------------------------------------------------------------------------
module feistel_mix_f
   import feistel_pkg::*;
(
   input  word_t x,
   output word_t y
);

   logic [3:0] p10, q10, p20, q20;
   logic [3:0] q11, p11, q21, p21;
   logic [3:0] p12, q12, p22, q22;

   // layer 1: independent substitution of each nibble
   assign p10 = P_SBOX[x[15:12]];
   assign q10 = Q_SBOX[x[11:8]];
   assign p20 = P_SBOX[x[7:4]];
   assign q20 = Q_SBOX[x[3:0]];

   // layer 2: each lookup index is formed from two bit-pairs of neighbouring
   // nibbles, which spreads every input nibble across the word
   assign q11 = Q_SBOX[(p10 & 4'hC) | (q10 >> 2)];
   assign p11 = P_SBOX[{p10[1:0], p20[3:2]}];
   assign q21 = Q_SBOX[{q10[1:0], q20[3:2]}];
   assign p21 = P_SBOX[{p20[1:0], q20[1:0]}];

   // layer 3
   assign p12 = P_SBOX[(q11 & 4'hC) | (p11 >> 2)];
   assign q12 = Q_SBOX[{q11[1:0], q21[3:2]}];
   assign p22 = P_SBOX[{p11[1:0], p21[3:2]}];
   assign q22 = Q_SBOX[{q21[1:0], p21[1:0]}];

   assign y = {p12, q12, p22, q22};

endmodule

// File: rtl/feistel_decrypt_engine.sv
// -----------------------------------------------------------------------------
// feistel_decrypt_engine
// Iterative decryption engine: undoes ROUNDS Feistel encryption stages, one
// inverse round per clock, on a 4x16-bit block with a single 16-bit key.
// Parameters:
//   ROUNDS : number of stages to undo (1..255)
// Ports:
//   clk   : system clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of feistel_decrypt_engine_if (in/out handshakes, busy)
// Timing: block accepted at edge T, out_valid high from edge T+ROUNDS until
// the edge on which out_ready is seen; one block per ROUNDS+2 cycles at most.
// -----------------------------------------------------------------------------
module feistel_decrypt_engine
   import feistel_pkg::*;
#(
   parameter int ROUNDS = 8
)(
   input logic                     clk,
   input logic                     rst_n,
   feistel_decrypt_engine_if.slave bus
);

   localparam int CW = $clog2(ROUNDS + 1);

   state_t        state;
   block_t        s;
   block_t        s_next;
   word_t         k;
   word_t         f_s1;
   word_t         f_s2;
   logic [CW-1:0] cnt;
   logic          in_ready_r;
   logic          out_valid_r;
   logic          busy_r;

   feistel_mix_f u_f_s1 (
      .x (s.w1),
      .y (f_s1)
   );

   feistel_mix_f u_f_s2 (
      .x (s.w2),
      .y (f_s2)
   );

   assign s_next = inv_round(s, k, f_s1, f_s2);

   // All handshake outputs are registered so in_ready never depends
   // combinationally on in_valid; the state registers reset to zero, which
   // is what lets o_dN be wired straight to them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         s           <= '0;
         k           <= '0;
         cnt         <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (bus.in_valid && in_ready_r) begin
                  s          <= {bus.i_d0, bus.i_d1, bus.i_d2, bus.i_d3};
                  k          <= bus.key;
                  cnt        <= '0;
                  state      <= ST_RUN;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
               end
            end
            ST_RUN: begin
               s   <= s_next;
               cnt <= cnt + 1'b1;
               // the edge that performs the last round also raises out_valid
               if (cnt == CW'(ROUNDS - 1)) begin
                  state       <= ST_DONE;
                  out_valid_r <= 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  state       <= ST_IDLE;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
               end
            end
            default: begin
               state       <= ST_IDLE;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.o_d0      = s.w0;
   assign bus.o_d1      = s.w1;
   assign bus.o_d2      = s.w2;
   assign bus.o_d3      = s.w3;

endmodule

// File: doc/feistel_decrypt_engine.md
Name: feistel_decrypt_engine

Overview:
- Iterative decryption engine; exact inverse of the 4x16-bit Feistel encryption stage chain used by the HW accelerator.
- Accepts one 64-bit ciphertext block and a 16-bit key over a valid/ready handshake.
- Applies ROUNDS inverse rounds, one per clock, and presents the plaintext over a valid/ready output handshake.
- Sits on the accelerator's receive path, facing the RISC-V side.

Parameters:
- ROUNDS, 8: number of encryption stages to undo; legal range 1..255.
- CW, $clog2(ROUNDS+1): round counter width (derived, not overridden).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  ciphertext block and key valid.
- in_ready  out  1  engine can accept a block.
- i_d0, i_d1, i_d2, i_d3  in  16 each  ciphertext words.
- key  in  16  round key, the same for all rounds.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  downstream accepts plaintext.
- o_d0, o_d1, o_d2, o_d3  out  16 each  plaintext words.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Mixing function F(x), x = {a,b,c,d} as nibbles, MSB first:
  - P = {3,15,14,0,5,4,11,12,13,10,9,6,7,8,2,1}.
  - Q = {9,14,5,6,10,2,3,12,15,0,4,13,7,11,1,8}.
  - P and Q are constant ROMs with no clock and no reset.
- F stage 1: p10 = P[a], q10 = Q[b], p20 = P[c], q20 = Q[d].
- F stage 2:
  - q11 = Q[(p10&4'hC) | (q10>>2)]
  - p11 = P[{p10[1:0], p20[3:2]}]
  - q21 = Q[{q10[1:0], q20[3:2]}]
  - p21 = P[{p20[1:0], q20[1:0]}]
- F stage 3:
  - p12 = P[(q11&4'hC) | (p11>>2)]
  - q12 = Q[{q11[1:0], q21[3:2]}]
  - p22 = P[{p11[1:0], p21[3:2]}]
  - q22 = Q[{q21[1:0], p21[1:0]}]
- F result: F(x) = {p12, q12, p22, q22}.
- Inverse round, state words s0..s3 → n0..n3:
  - n0 = ~s1 ^ K
  - n1 = s3 ^ F(s2)
  - n2 = s0 ^ F(s1)
  - n3 = ~s2 ^ K
  - All arithmetic is 16-bit; no carries.
- FSM states are IDLE, RUN, DONE. Reset state: IDLE.
- Reset values: in_ready=1 (follows IDLE), out_valid=0, busy=0, o_d0..o_d3=0, state registers=0, K=0, counter=0.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch i_d0..i_d3 into s0..s3, latch key into K, clear counter, go to RUN.
- RUN:
  - in_ready=0.
  - Each clock: s ← inverse_round(s), counter++.
  - When counter reaches ROUNDS-1 on an edge, that edge also moves to DONE.
- DONE:
  - out_valid=1; o_dN are driven directly from sN and held stable.
  - On out_ready, go to IDLE at that edge.
  - out_valid deasserts the following cycle.
- Latency: block accepted at edge T; out_valid is high from edge T+ROUNDS onward.
- Throughput: one block per ROUNDS+2 cycles when out_ready=1.
- Handshakes:
  - in_ready does not depend combinationally on in_valid.
  - in_valid/data/key changes while in_ready=0 are ignored.
  - In DONE with out_ready=0, the output holds indefinitely.
- Reset mid-operation (RUN or DONE): the block is discarded and all outputs return to reset values asynchronously; no partial output is ever flagged valid.
- ROUNDS=1: RUN lasts exactly one cycle.

Decomposition:
- Package feistel_pkg holds:
  - P_SBOX and Q_SBOX 16x4 constant arrays.
  - WORD_W=16.
  - A function inv_round reference used by both RTL and bench.
- Sub-module feistel_mix_f: purely combinational F. Instantiate it twice in the engine, on s1 and on s2.
- The engine holds the FSM, counter, key register and state registers.

Test Plan:
- F golden values: drive feistel_mix_f with 16'h0000 → 16'h4A27; with 16'hFFFF → 16'h4242.
- Single round (ROUNDS=1):
  - Stimulus: key=0, i_d0..3 = 1234, 0000, FFFF, 5678 (hex).
  - Required response: o_d0..3 = FFFF, 143A, 5813, 0000 (hex).
  - Timing: out_valid exactly 1 cycle after acceptance.
- Round-trip (ROUNDS=8):
  - Build ciphertext with a bench model of 8 chained encryption stages; use random key and data, 200 blocks.
  - Every output must equal the original plaintext; latency is exactly 8 cycles each.
- Backpressure:
  - Hold out_ready=0 for 20 cycles in DONE.
  - Required: outputs stable, in_ready=0, in_valid pulses ignored.
  - Then out_ready=1 → IDLE next edge, and the next block is accepted.
- Reset mid-RUN:
  - Assert rst_n=0 at round 3 without a clock edge.
  - Required: out_valid, busy, o_dN are 0 immediately; in_ready=1.
  - A fresh block after release decrypts correctly.
- Back-to-back traffic:
  - in_valid held high, out_ready=1.
  - Required: accept, ROUNDS RUN cycles, one DONE cycle, IDLE accept; no block lost or duplicated over 50 blocks.
